// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin write-back arbiter and write-port sequencer for the register file.
// NUM_REQ producers compete for the single write-data bus through valid/ready
// handshakes. Each accepted write becomes a one-cycle registered pulse on
// wr_en/wr_data. The write in flight is published on pend_valid/pend_addr.
//
// Optional build macro: RF_X0_WRITE_BLOCK_EN
//   When defined, writes to address 0 are still accepted and reported on
//   pend_valid/pend_addr. They never raise wr_en, so register 0 stays constant.

module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic [(2**ADDR_WIDTH)-1:0]     wr_en,
    output logic                           pend_valid,
    output logic [ADDR_WIDTH-1:0]          pend_addr,
    output logic [$clog2(NUM_REQ)-1:0]     last_grant
);

    localparam int NUM_EN = 2**ADDR_WIDTH;
    localparam int PTR_W  = $clog2(NUM_REQ);
    // One extra bit so that rr_ptr + offset never wraps before the modulo fold.
    localparam int CND_W  = PTR_W + 1;

`ifdef RF_X0_WRITE_BLOCK_EN
    localparam logic X0_BLOCK = 1'b1;
`else
    localparam logic X0_BLOCK = 1'b0;
`endif

    // Registered state
    logic [PTR_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic [PTR_W-1:0]      last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic [NUM_EN-1:0]     wr_en_q,      wr_en_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q,  pend_addr_d;

    // Arbitration results
    logic [NUM_REQ-1:0]    grant_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic                  accept_s;
    logic [CND_W-1:0]      cand_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  x0_block_s;

    // Round-robin search: the first valid requester at or above rr_ptr (wrapping) wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        accept_s    = 1'b0;
        cand_s      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s = {1'b0, rr_ptr_q} + CND_W'(off);
            if (cand_s >= CND_W'(NUM_REQ)) begin
                cand_s = cand_s - CND_W'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!stall && !accept_s && req_valid[cand_s[PTR_W-1:0]]) begin
                grant_s[cand_s[PTR_W-1:0]] = 1'b1;
                grant_idx_s                = cand_s[PTR_W-1:0];
                accept_s                   = 1'b1;
            end else begin
                accept_s = accept_s;
            end
        end
    end

    // Multiplex the granted requester's address and data (one-hot AND-OR).
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_addr_s = sel_addr_s | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_s = sel_data_s | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state for pointer, grant history and the write stage.
    always_comb begin
        x0_block_s = X0_BLOCK && (sel_addr_s == '0);
        wr_en_d    = '0;
        if (accept_s) begin
            if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PTR_W'(1);
            end
            last_grant_d = grant_idx_s;
            wr_data_d    = sel_data_s;
            pend_valid_d = 1'b1;
            pend_addr_d  = sel_addr_s;
            for (int e = 0; e < NUM_EN; e++) begin
                wr_en_d[e] = !x0_block_s && (sel_addr_s == ADDR_WIDTH'(e));
            end
        end else begin
            rr_ptr_d     = rr_ptr_q;
            last_grant_d = last_grant_q;
            wr_data_d    = wr_data_q;
            pend_valid_d = 1'b0;
            pend_addr_d  = pend_addr_q;
        end
    end

    // State registers; reset drops any write that was about to be applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            last_grant_q <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign req_ready  = grant_s;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: scenario tasks plus a scoreboard
// that predicts each acceptance and checks the write pulse one edge later.
`timescale 1ns/1ps
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NE = 32;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     wr_data;
    logic [NE-1:0]     wr_en;
    logic              pend_valid;
    logic [AW-1:0]     pend_addr;
    logic [PW-1:0]     last_grant;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_data(wr_data), .wr_en(wr_en),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           e_w;
    wr_t           p_w;
    bit            sb_on = 1'b0;
    int            m_ptr = 0;
    logic [NR-1:0] m_rdy;
    bit            m_found;
    int            m_g;
    int            m_c;
    logic [NE-1:0] exp_en;
    logic [DW-1:0] rf [NE];

    // Expected one-hot enable for a write to address a.
    function automatic logic [NE-1:0] en_of(input logic [AW-1:0] a);
        logic [NE-1:0] v;
        v = '0;
`ifdef RF_X0_WRITE_BLOCK_EN
        if (a != '0) v[a] = 1'b1;
`else
        v[a] = 1'b1;
`endif
        return v;
    endfunction

    // Behavioural register file driven by the write port.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NE; i++) if (wr_en[i]) rf[i] <= wr_data;
        end
    end

    // Scoreboard: check last edge's write, then predict this cycle's grant.
    always @(negedge clk) begin
        if (sb_on && !rst) begin
            if (exp_q.size() > 0) begin
                e_w    = exp_q.pop_front();
                exp_en = en_of(e_w.addr);
                n_cmp++;
                if (wr_en !== exp_en || wr_data !== e_w.data || pend_valid !== 1'b1 ||
                    pend_addr !== e_w.addr || last_grant !== e_w.idx) begin
                    n_fail++;
                    $display("FAIL sb_write: got wr_en=%h data=%h pend=%b addr=%0d lg=%0d, need wr_en=%h data=%h pend=1 addr=%0d lg=%0d",
                             wr_en, wr_data, pend_valid, pend_addr, last_grant,
                             exp_en, e_w.data, e_w.addr, e_w.idx);
                end
            end else begin
                n_cmp++;
                if (wr_en !== '0 || pend_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_idle: got wr_en=%h pend=%b, need wr_en=0 pend=0", wr_en, pend_valid);
                end
            end
            #2;
            if (sb_on && !rst) begin
                m_rdy   = '0;
                m_found = 1'b0;
                m_g     = 0;
                if (!stall) begin
                    for (int off = 0; off < NR; off++) begin
                        m_c = (m_ptr + off) % NR;
                        if (!m_found && req_valid[m_c]) begin
                            m_found = 1'b1;
                            m_g     = m_c;
                        end
                    end
                end
                if (m_found) m_rdy[m_g] = 1'b1;
                n_cmp++;
                if (req_ready !== m_rdy) begin
                    n_fail++;
                    $display("FAIL sb_ready: got %b, need %b", req_ready, m_rdy);
                end
                if (m_found) begin
                    p_w.addr = req_addr[m_g*AW +: AW];
                    p_w.data = req_data[m_g*DW +: DW];
                    p_w.idx  = PW'(m_g);
                    exp_q.push_back(p_w);
                    m_ptr = (m_g + 1) % NR;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (wr_en !== '0) begin n_fail++; $display("FAIL rst_wr_en: got %h, need 0", wr_en); end
        n_cmp++; if (wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data: got %h, need 0", wr_data); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend_valid: got %b, need 0", pend_valid); end
        n_cmp++; if (pend_addr !== '0) begin n_fail++; $display("FAIL rst_pend_addr: got %0d, need 0", pend_addr); end
        n_cmp++; if (last_grant !== '0) begin n_fail++; $display("FAIL rst_last_grant: got %0d, need 0", last_grant); end
        rst = 1'b0;
        @(negedge clk); #1 sb_on = 1'b1;
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        req_valid = 4'b0001; req_addr[0 +: AW] = 5'd7; req_data[0 +: DW] = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (wr_en !== 32'h0000_0080) begin n_fail++; $display("FAIL mid_pulse: got %h, need 00000080", wr_en); end
        rst = 1'b1; sb_on = 1'b0;
        #1;
        n_cmp++; if (wr_en !== '0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %h, need 0", wr_en); end
        n_cmp++; if (wr_data !== '0) begin n_fail++; $display("FAIL mid_rst_wr_data: got %h, need 0", wr_data); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pend: got %b, need 0", pend_valid); end
        n_cmp++; if (last_grant !== '0) begin n_fail++; $display("FAIL mid_rst_lg: got %0d, need 0", last_grant); end
        @(negedge clk);
        exp_q.delete(); m_ptr = 0; rst = 1'b0;
        #1 sb_on = 1'b1;
    endtask

    task automatic test_all_four;
        logic [DW-1:0] d;
        @(negedge clk);
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 1);
            req_data[i*DW +: DW] = 32'h11 * (i + 1);
        end
        for (int c = 0; c < NR; c++) begin
            @(negedge clk);
            req_valid[c] = 1'b0;
            #1;
            d = 32'h11 * (c + 1);
            n_cmp++;
            if (wr_en !== en_of(AW'(c + 1)) || wr_data !== d) begin
                n_fail++;
                $display("FAIL b2b_pulse%0d: got wr_en=%h data=%h, need wr_en=%h data=%h", c, wr_en, wr_data, en_of(AW'(c + 1)), d);
            end
            n_cmp++;
            if (last_grant !== PW'(c)) begin n_fail++; $display("FAIL b2b_grant%0d: got %0d, need %0d", c, last_grant, c); end
        end
    endtask

    task automatic test_rr_ptr2;
        @(negedge clk);
        req_valid = 4'b0010; req_addr[1*AW +: AW] = 5'd9; req_data[1*DW +: DW] = 32'h9999;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (last_grant !== 2'd1) begin n_fail++; $display("FAIL rr_setup_lg: got %0d, need 1", last_grant); end
        @(negedge clk);
        req_valid = 4'b1010;
        req_addr[1*AW +: AW] = 5'd10; req_data[1*DW +: DW] = 32'hA1;
        req_addr[3*AW +: AW] = 5'd11; req_data[3*DW +: DW] = 32'hB3;
        #3;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_ready: got %b, need 1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        n_cmp++; if (last_grant !== 2'd3 || wr_en !== en_of(5'd11)) begin n_fail++; $display("FAIL rr_first: got lg=%0d wr_en=%h, need lg=3 wr_en=%h", last_grant, wr_en, en_of(5'd11)); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        n_cmp++; if (last_grant !== 2'd1 || wr_en !== en_of(5'd10)) begin n_fail++; $display("FAIL rr_second: got lg=%0d wr_en=%h, need lg=1 wr_en=%h", last_grant, wr_en, en_of(5'd10)); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        stall = 1'b1; req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 5'd5; req_data[2*DW +: DW] = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            #3;
            n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL stall_ready%0d: got %b, need 0000", k, req_ready); end
            @(negedge clk);
            #1;
            n_cmp++; if (wr_en !== '0) begin n_fail++; $display("FAIL stall_wr_en%0d: got %h, need 0", k, wr_en); end
        end
        stall = 1'b0;
        #2;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ready: got %b, need 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (wr_en !== en_of(5'd5) || wr_data !== 32'h5555_5555) begin n_fail++; $display("FAIL stall_write: got wr_en=%h data=%h, need wr_en=%h data=55555555", wr_en, wr_data, en_of(5'd5)); end
    endtask

    task automatic test_x0;
        logic [DW-1:0] exp_r0;
        @(negedge clk);
        req_valid = 4'b0001; req_addr[0 +: AW] = 5'd0; req_data[0 +: DW] = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (pend_valid !== 1'b1 || pend_addr !== 5'd0) begin n_fail++; $display("FAIL x0_pend: got %b/%0d, need 1/0", pend_valid, pend_addr); end
`ifdef RF_X0_WRITE_BLOCK_EN
        exp_en = '0;
        exp_r0 = 32'h0;
`else
        exp_en = 32'h0000_0001;
        exp_r0 = 32'hFFFF_FFFF;
`endif
        n_cmp++; if (wr_en !== exp_en) begin n_fail++; $display("FAIL x0_wr_en: got %h, need %h", wr_en, exp_en); end
        @(negedge clk);
        #1;
        n_cmp++; if (rf[0] !== exp_r0) begin n_fail++; $display("FAIL x0_reg: got %h, need %h", rf[0], exp_r0); end
    endtask

    task automatic test_sp;
        @(negedge clk);
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 5'd2; req_data[2*DW +: DW] = 32'h0000_1000;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (wr_en !== 32'h0000_0004) begin n_fail++; $display("FAIL sp_pulse: got %h, need 00000004", wr_en); end
        @(negedge clk);
        #1;
        n_cmp++; if (wr_en !== '0) begin n_fail++; $display("FAIL sp_one_cycle: got %h, need 0", wr_en); end
        n_cmp++; if (rf[2] !== 32'h0000_1000) begin n_fail++; $display("FAIL sp_reg: got %h, need 00001000", rf[2]); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_all_four();
        test_rr_ptr2();
        test_stall();
        test_x0();
        test_sp();
        repeat (2) @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
